// File: rtl/feedback_sequencer.sv
// feedback_sequencer: drives the RGB LED and the piezo from the lock FSM
// state code. Colours follow the current state (optionally blinking),
// while finite beep patterns replay once per state entry and continuous
// tones (lockout, siren) run for as long as the state is held.
module feedback_sequencer #(
  parameter int COLOR_W    = 4,
  parameter int BLINK_HALF = 500,
  parameter int BEEP_LEN   = 200,
  parameter int HIGH_DIV   = 1,
  parameter int LOW_DIV    = 4
) (
  input  logic                   clk_1khz,
  input  logic                   rst,
  input  logic [3:0]             state,
  input  logic                   mute,
  output logic [3*COLOR_W-1:0]   rgb_out,
  output logic                   piezo_pwm,
  output logic                   busy
);

  localparam logic [3:0] ST_SUCCESS   = 4'h7;
  localparam logic [3:0] ST_FAIL      = 4'h8;
  localparam logic [3:0] ST_LOCKOUT   = 4'h9;
  localparam logic [3:0] ST_EMERGENCY = 4'hA;

  localparam int MAX_DIV = (HIGH_DIV > LOW_DIV) ? HIGH_DIV : LOW_DIV;
  localparam int SEG_W   = $clog2(3 * BEEP_LEN + 1);
  localparam int DIV_W   = $clog2(MAX_DIV + 1);
  localparam int BLK_W   = $clog2(BLINK_HALF + 1);

  localparam logic [SEG_W-1:0] BEEP_LAST  = SEG_W'(BEEP_LEN - 1);
  localparam logic [SEG_W-1:0] LONG_LAST  = SEG_W'(3 * BEEP_LEN - 1);
  localparam logic [DIV_W-1:0] HIGH_LAST  = DIV_W'(HIGH_DIV - 1);
  localparam logic [DIV_W-1:0] LOW_LAST   = DIV_W'(LOW_DIV - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_HALF - 1);

  localparam logic [COLOR_W-1:0] C_MAX  = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] C_HALF = C_MAX >> 1;
  localparam logic [COLOR_W-1:0] C_ZERO = '0;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_BEEP1 = 3'd1,
    P_GAP   = 3'd2,
    P_BEEP2 = 3'd3,
    P_LONG  = 3'd4,
    P_CONT  = 3'd5
  } pat_state_t;

  // Pattern state kept as a named signal so checkers can bind to it.
  pat_state_t pat_state, pat_n;

  logic [3:0]         state_q;
  logic [BLK_W-1:0]   blink_cnt, blink_cnt_n;
  logic               phase, phase_n, phase_edge;
  logic [SEG_W-1:0]   seg_cnt, seg_n;
  logic [DIV_W-1:0]   div_cnt, div_n, div_last;
  logic               tone, tone_n;
  logic               changed, entry, seg_start, silent, use_high;
  logic [3*COLOR_W-1:0] rgb_n;

  // Register all state, counters and outputs; reset clears everything
  // except the blink phase, which restarts lit.
  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      state_q   <= 4'h0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      pat_state <= P_IDLE;
      seg_cnt   <= '0;
      div_cnt   <= '0;
      tone      <= 1'b0;
      rgb_out   <= '0;
      piezo_pwm <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state;
      blink_cnt <= blink_cnt_n;
      phase     <= phase_n;
      pat_state <= pat_n;
      seg_cnt   <= seg_n;
      div_cnt   <= div_n;
      tone      <= tone_n;
      rgb_out   <= rgb_n;
      piezo_pwm <= tone_n & ~mute;
      busy      <= (pat_n != P_IDLE);
    end
  end

  // Next-state logic: blink timer, pattern FSM, tone divider and colour.
  always_comb begin
    changed = (state != state_q);
    entry   = changed && ((state == ST_SUCCESS) || (state == ST_FAIL) ||
                          (state == ST_LOCKOUT) || (state == ST_EMERGENCY));

    // Blink timer: any state change restarts it in the lit phase.
    blink_cnt_n = blink_cnt + 1'b1;
    phase_n     = phase;
    phase_edge  = 1'b0;
    if (changed) begin
      blink_cnt_n = '0;
      phase_n     = 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_n = '0;
      phase_n     = ~phase;
      phase_edge  = 1'b1;
    end

    // Pattern FSM. seg_start restarts the divider with the piezo high;
    // silent holds the piezo low between segments.
    pat_n     = pat_state;
    seg_n     = '0;
    seg_start = 1'b0;
    silent    = 1'b1;
    use_high  = 1'b0;
    if (entry) begin
      seg_start = 1'b1;
      silent    = 1'b0;
      case (state)
        ST_SUCCESS: begin pat_n = P_BEEP1; use_high = 1'b1; end
        ST_FAIL:    pat_n = P_LONG;
        ST_LOCKOUT: pat_n = P_CONT;
        default:    begin pat_n = P_CONT; use_high = 1'b1; end
      endcase
    end else if (changed) begin
      pat_n = P_IDLE;
    end else begin
      case (pat_state)
        P_BEEP1: begin
          if (seg_cnt == BEEP_LAST) begin
            pat_n = P_GAP;
          end else begin
            seg_n    = seg_cnt + 1'b1;
            silent   = 1'b0;
            use_high = 1'b1;
          end
        end
        P_GAP: begin
          if (seg_cnt == BEEP_LAST) begin
            pat_n     = P_BEEP2;
            seg_start = 1'b1;
            silent    = 1'b0;
            use_high  = 1'b1;
          end else begin
            seg_n = seg_cnt + 1'b1;
          end
        end
        P_BEEP2: begin
          if (seg_cnt == BEEP_LAST) begin
            pat_n = P_IDLE;
          end else begin
            seg_n    = seg_cnt + 1'b1;
            silent   = 1'b0;
            use_high = 1'b1;
          end
        end
        P_LONG: begin
          if (seg_cnt == LONG_LAST) begin
            pat_n = P_IDLE;
          end else begin
            seg_n  = seg_cnt + 1'b1;
            silent = 1'b0;
          end
        end
        P_CONT: begin
          // Each blink phase edge starts a fresh tone segment.
          seg_start = phase_edge;
          if (state == ST_EMERGENCY) begin
            silent   = 1'b0;
            use_high = phase_n;
          end else begin
            silent   = ~phase_n;
          end
        end
        default: pat_n = P_IDLE;
      endcase
    end

    // Tone divider: toggles the square wave every DIV cycles.
    div_last = use_high ? HIGH_LAST : LOW_LAST;
    if (silent) begin
      tone_n = 1'b0;
      div_n  = '0;
    end else if (seg_start) begin
      tone_n = 1'b1;
      div_n  = '0;
    end else if (div_cnt == div_last) begin
      tone_n = ~tone;
      div_n  = '0;
    end else begin
      tone_n = tone;
      div_n  = div_cnt + 1'b1;
    end

    // Colour, ordered {R,G,B}; blinking colours go dark in phase 0.
    case (state)
      ST_SUCCESS:   rgb_n = {C_ZERO, C_MAX, C_ZERO};
      ST_FAIL:      rgb_n = {C_MAX, C_ZERO, C_ZERO};
      ST_LOCKOUT:   rgb_n = phase_n ? {C_MAX, C_ZERO, C_ZERO} : '0;
      ST_EMERGENCY: rgb_n = phase_n ? {C_MAX, C_HALF, C_ZERO} : '0;
      default:      rgb_n = '0;
    endcase
  end

endmodule

// File: tb/tb_feedback_sequencer.sv
// Directed bench for feedback_sequencer with default parameters.
module tb_feedback_sequencer;

  logic        clk_1khz;
  logic        rst;
  logic [3:0]  state;
  logic        mute;
  logic [11:0] rgb_out;
  logic        piezo_pwm;
  logic        busy;

  int errors;
  int checks;

  feedback_sequencer dut (
    .clk_1khz  (clk_1khz),
    .rst       (rst),
    .state     (state),
    .mute      (mute),
    .rgb_out   (rgb_out),
    .piezo_pwm (piezo_pwm),
    .busy      (busy)
  );

  // Clock and reset
  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk_1khz);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [11:0] rgb,
                           input logic pz, input logic bz);
    check({tag, ".rgb"}, 32'(rgb_out), 32'(rgb));
    check({tag, ".piezo"}, 32'(piezo_pwm), 32'(pz));
    check({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  // Expected tones at cycle j of a tone segment.
  function automatic logic high_tone(input int j);
    return (j % 2) == 0;
  endfunction

  function automatic logic low_tone(input int j);
    return ((j / 4) % 2) == 0;
  endfunction

  function automatic logic [11:0] succ_piezo(input int k);
    if (k < 200) return 12'(high_tone(k));
    if (k < 400) return 12'h0;
    return 12'(high_tone(k - 400));
  endfunction

  // Driver and scoreboard sequence
  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    state  = 4'h7;
    mute   = 1'b0;

    // Reset state
    tick();
    tick();
    check_all("reset", 12'h000, 1'b0, 1'b0);

    // SUCCESS double-beep after reset release
    rst = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick();
      check_all($sformatf("succ[%0d]", k), 12'h0F0, succ_piezo(k)[0], 1'b1);
    end
    tick();
    check_all("succ.end", 12'h0F0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check_all($sformatf("succ.hold[%0d]", k), 12'h0F0, 1'b0, 1'b0);
    end

    // FAIL, muted
    state = 4'h8;
    mute  = 1'b1;
    for (int k = 0; k < 600; k++) begin
      tick();
      check_all($sformatf("fail_mute[%0d]", k), 12'hF00, 1'b0, 1'b1);
    end
    tick();
    check_all("fail_mute.end", 12'hF00, 1'b0, 1'b0);
    mute = 1'b0;

    // EMERGENCY siren, 2000 cycles
    state = 4'hA;
    for (int k = 0; k < 2000; k++) begin
      logic lit;
      int   j;
      tick();
      lit = ((k / 500) % 2) == 0;
      j   = k % 500;
      check_all($sformatf("emerg[%0d]", k), lit ? 12'hF70 : 12'h000,
                lit ? high_tone(j) : low_tone(j), 1'b1);
    end

    // LOCKOUT for 1000 cycles, then IDLE
    state = 4'h9;
    for (int k = 0; k < 1000; k++) begin
      logic lit;
      tick();
      lit = k < 500;
      check_all($sformatf("lock[%0d]", k), lit ? 12'hF00 : 12'h000,
                lit ? low_tone(k) : 1'b0, 1'b1);
    end
    state = 4'h0;
    tick();
    check_all("lock.idle", 12'h000, 1'b0, 1'b0);
    tick();
    check_all("idle.hold", 12'h000, 1'b0, 1'b0);

    // SUCCESS aborted by FAIL after 100 cycles
    state = 4'h7;
    for (int k = 0; k < 100; k++) begin
      tick();
      check_all($sformatf("abort.succ[%0d]", k), 12'h0F0, high_tone(k), 1'b1);
    end
    state = 4'h8;
    for (int k = 0; k < 600; k++) begin
      tick();
      check_all($sformatf("abort.fail[%0d]", k), 12'hF00, low_tone(k), 1'b1);
    end
    tick();
    check_all("abort.end", 12'hF00, 1'b0, 1'b0);

    // Reset mid-FAIL, then full replay with a muted window
    state = 4'h0;
    tick();
    state = 4'h8;
    for (int k = 0; k < 300; k++) begin
      tick();
      check_all($sformatf("pre_rst[%0d]", k), 12'hF00, low_tone(k), 1'b1);
    end
    rst = 1'b1;
    #1;
    check_all("rst.async", 12'h000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("rst.hold[%0d]", k), 12'h000, 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int k = 0; k < 600; k++) begin
      logic m;
      m    = (k >= 100) && (k < 200);
      mute = m;
      tick();
      check_all($sformatf("replay[%0d]", k), 12'hF00, low_tone(k) & ~m, 1'b1);
    end
    mute = 1'b0;
    tick();
    check_all("replay.end", 12'hF00, 1'b0, 1'b0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
